// File: rtl/pc_target_lut.sv
// Programmable branch-target lookup table with registered 1-cycle lookups and a post-reset clear sweep.
// Define PC_LUT_PRELOAD_EN to have the sweep preload entries 0..3 with fixed absolute targets.
module pc_target_lut #(
  parameter int unsigned D     = 10,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_all,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [D-1:0]  wr_data,
  input  logic          wr_rel,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  input  logic [D-1:0]  pc,
  output logic          rd_valid,
  output logic [D-1:0]  target,
  output logic          rd_miss,
  output logic          busy
);

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StIdle  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] rel_q, rel_d;
  logic [D-1:0]     data_q [DEPTH];
  logic [D-1:0]     data_d [DEPTH];
  logic             rd_valid_q, rd_valid_d;
  logic             rd_miss_q, rd_miss_d;
  logic [D-1:0]     target_q, target_d;

  logic             idle;
  logic             wr_fire;
  logic             rd_fire;
  logic             init_valid;
  logic [D-1:0]     init_data;

  assign idle    = (state_q == StIdle);
  // clr_all wins over any same-cycle access
  assign wr_fire = idle & wr_en & ~clr_all;
  assign rd_fire = idle & rd_req & ~clr_all;

`ifdef PC_LUT_PRELOAD_EN
  always_comb begin
    init_valid = 1'b0;
    init_data  = '0;
    case (idx_q)
      AW'(0): begin init_valid = 1'b1; init_data = D'(0);  end
      AW'(1): begin init_valid = 1'b1; init_data = D'(11); end
      AW'(2): begin init_valid = 1'b1; init_data = D'(41); end
      AW'(3): begin init_valid = 1'b1; init_data = D'(99); end
      default: ;
    endcase
  end
`else
  assign init_valid = 1'b0;
  assign init_data  = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StClear: begin
        idx_d = idx_q + 1'b1;
        if (clr_all) begin
          idx_d = '0;
        end else if (idx_q == AW'(DEPTH - 1)) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (clr_all) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    rel_d   = rel_q;
    data_d  = data_q;
    if (!idle) begin
      valid_d[idx_q] = init_valid;
      rel_d[idx_q]   = 1'b0;
      data_d[idx_q]  = init_data;
    end else if (wr_fire) begin
      valid_d[wr_addr] = 1'b1;
      rel_d[wr_addr]   = wr_rel;
      data_d[wr_addr]  = wr_data;
    end
  end

  // Lookup reads the current (pre-write) table, giving read-before-write on same-address collisions
  always_comb begin
    rd_valid_d = rd_fire;
    rd_miss_d  = rd_fire & ~valid_q[rd_addr];
    target_d   = target_q;
    if (rd_fire) begin
      if (!valid_q[rd_addr]) begin
        target_d = pc + D'(1);
      end else if (rel_q[rd_addr]) begin
        target_d = pc + data_q[rd_addr];
      end else begin
        target_d = data_q[rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StClear;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_valid_d;
      rd_miss_q  <= rd_miss_d;
      target_q   <= target_d;
    end
  end

  // Table storage needs no reset: the sweep initialises it before any access is accepted
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    rel_q   <= rel_d;
    data_q  <= data_d;
  end

  assign rd_valid = rd_valid_q;
  assign rd_miss  = rd_miss_q;
  assign target   = target_q;
  assign busy     = ~idle;

endmodule

// File: tb/tb_pc_target_lut.sv
// Bench for pc_target_lut: directed literal checks plus randomized traffic against a table model.
module tb_pc_target_lut;
  localparam int D     = 10;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_all = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [D-1:0]  wr_data = '0;
  logic          wr_rel = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [D-1:0]  pc = '0;
  logic          rd_valid;
  logic [D-1:0]  target;
  logic          rd_miss;
  logic          busy;

  pc_target_lut #(.D(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr_all(clr_all), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_rel(wr_rel), .rd_req(rd_req), .rd_addr(rd_addr), .pc(pc),
    .rd_valid(rd_valid), .target(target), .rd_miss(rd_miss), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Behavioural model: table contents, remaining sweep cycles, expected outputs
  bit         m_valid [DEPTH];
  bit         m_rel   [DEPTH];
  bit [D-1:0] m_data  [DEPTH];
  int         m_left = 0;
  bit         m_init = 0;
  bit         m_rv = 0, m_miss = 0;
  bit [D-1:0] m_tgt = '0;

  function automatic void sweep_entry(input int p);
    m_valid[p] = 0;
    m_rel[p]   = 0;
    m_data[p]  = '0;
`ifdef PC_LUT_PRELOAD_EN
    if (p < 4) begin
      m_valid[p] = 1;
      m_data[p]  = (p == 0) ? 10'd0 : (p == 1) ? 10'd11 : (p == 2) ? 10'd41 : 10'd99;
    end
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = DEPTH;
      m_rv = 0; m_miss = 0; m_tgt = '0;
      m_init = 1;
    end else if (m_left > 0) begin
      sweep_entry(DEPTH - m_left);
      m_left = m_left - 1;
      m_rv = 0; m_miss = 0;
      if (clr_all) m_left = DEPTH;
    end else begin
      m_rv = 0; m_miss = 0;
      if (clr_all) begin
        m_left = DEPTH;
      end else begin
        if (rd_req) begin
          m_rv = 1;
          if (!m_valid[rd_addr]) begin
            m_miss = 1;
            m_tgt = pc + 10'd1;
          end else if (m_rel[rd_addr]) begin
            m_tgt = pc + m_data[rd_addr];
          end else begin
            m_tgt = m_data[rd_addr];
          end
        end
        if (wr_en) begin
          m_valid[wr_addr] = 1;
          m_rel[wr_addr]   = wr_rel;
          m_data[wr_addr]  = wr_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("busy", int'(busy), int'(m_left > 0));
      chk("rd_valid", int'(rd_valid), int'(m_rv));
      chk("rd_miss", int'(rd_miss), int'(m_miss));
      chk("target", int'(target), int'(m_tgt));
    end
  end

  // Entered at a negedge; counts negedges with busy high, holding rd_req throughout
  task automatic count_busy(output int cnt, output int rv);
    cnt = 0; rv = 0;
    while (busy && cnt < 40) begin
      rv += int'(rd_valid);
      rd_req = 1'b1; rd_addr = 4'd2; pc = 10'd40;
      cnt++;
      @(negedge clk);
    end
    rv += int'(rd_valid);
    rd_req = 1'b0;
  endtask

  task automatic do_write(input int a, input int d, input bit rel);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = D'(d); wr_rel = rel;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_lookup(input int a, input int p, output int rv, output int miss,
                           output int tg);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = AW'(a); pc = D'(p);
    @(negedge clk);
    rd_req = 1'b0;
    rv = int'(rd_valid); miss = int'(rd_miss); tg = int'(target);
  endtask

  int cnt, rv, miss, tg;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 1);
    chk("reset_target", int'(target), 0);
    rst_n = 1'b1;
    count_busy(cnt, rv);
    chk("t1_busy_cycles", cnt, 16);
    chk("t1_no_rd_valid_while_busy", rv, 0);

    do_lookup(2, 40, rv, miss, tg);
    chk("t2_rd_valid", rv, 1);
    chk("t2_target", tg, 41);
`ifdef PC_LUT_PRELOAD_EN
    chk("t2_miss", miss, 0);
`else
    chk("t2_miss", miss, 1);
`endif

    do_write(5, 'h3FB, 1'b1);
    do_lookup(5, 4, rv, miss, tg);
    chk("t3_rel_target", tg, 'h3FF);
    chk("t3_rel_miss", miss, 0);
    do_write(5, 'h002, 1'b1);
    do_lookup(5, 'h3FF, rv, miss, tg);
    chk("t3_wrap_target", tg, 'h001);

    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 10'd200; wr_rel = 1'b0;
    rd_req = 1'b1; rd_addr = 4'd7; pc = 10'd9;
    @(negedge clk);
    wr_en = 1'b0; rd_req = 1'b0;
    chk("t4_collide_miss", int'(rd_miss), 1);
    chk("t4_collide_target", int'(target), 10);
    do_lookup(7, 9, rv, miss, tg);
    chk("t4_after_target", tg, 200);
    chk("t4_after_miss", miss, 0);

    @(negedge clk);
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    count_busy(cnt, rv);
    chk("t5_busy_cycles", cnt, 16);
    do_lookup(5, 100, rv, miss, tg);
    chk("t5_miss", miss, 1);
    chk("t5_target", tg, 101);

    @(negedge clk);
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(cnt, rv);
    chk("t6_busy_after_reset", cnt, 16);

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_addr = AW'(i); pc = D'(i * 3);
      @(negedge clk);
      if (i > 0) chk("t6_b2b_valid", int'(rd_valid), 1);
    end
    rd_req = 1'b0;
    chk("t6_b2b_valid", int'(rd_valid), 1);
    @(negedge clk);
    chk("t6_b2b_end", int'(rd_valid), 0);

    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 399) != 0);
      clr_all = (m_left == 0) && ($urandom_range(0, 79) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = D'($urandom);
      wr_rel  = 1'($urandom);
      rd_req  = ($urandom_range(0, 1) == 0);
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      pc      = D'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1; clr_all = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
